// File: rtl/pc_unit.sv
// Program-counter unit: branch/jump/mret redirect, trap entry with EPC/cause,
// BOOT/RUN/HALT sequencing and a retired-instruction counter.
module pc_unit #(
   parameter int              XLEN         = 64,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
   parameter int              CNT_W        = 64
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             stall,
   input  logic [2:0]       pc_src,
   input  logic [2:0]       branch_cond,
   input  logic             zero,
   input  logic             lt,
   input  logic             ltu,
   input  logic [XLEN-1:0]  imm,
   input  logic [XLEN-1:0]  alu_result,
   input  logic             trap_req,
   input  logic             halt_req,
   input  logic             resume,
   output logic [XLEN-1:0]  pc_current,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             pc_valid,
   output logic [XLEN-1:0]  epc,
   output logic [1:0]       trap_cause,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t          state;
   logic            taken;
   logic            redirect;
   logic            misaligned;
   logic [XLEN-1:0] target;

   assign pc_plus4 = pc_current + XLEN'(4);

   always_comb begin
      taken = zero;
      case (branch_cond)
         3'b001:  taken = !zero;
         3'b100:  taken = lt;
         3'b101:  taken = !lt;
         3'b110:  taken = ltu;
         3'b111:  taken = !ltu;
         default: taken = zero;
      endcase
   end

   always_comb begin
      redirect = 1'b0;
      target   = pc_plus4;
      case (pc_src)
         3'b001: begin
            redirect = taken;
            if (taken)
               target = pc_current + imm;
         end
         3'b010: begin
            redirect = 1'b1;
            target   = pc_current + imm;
         end
         3'b011: begin
            redirect = 1'b1;
            target   = {alu_result[XLEN-1:1], 1'b0};
         end
         3'b100: begin
            redirect = 1'b1;
            target   = epc;
         end
         default: begin
            redirect = 1'b0;
            target   = pc_plus4;
         end
      endcase
   end

   // Only a selected redirect can fault; the sequential path stays aligned.
   assign misaligned = redirect && (target[1:0] != 2'b00);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= BOOT;
         pc_current <= RESET_VECTOR;
         pc_valid   <= 1'b0;
         epc        <= '0;
         trap_cause <= 2'b00;
         instret    <= '0;
      end else begin
         case (state)
            BOOT: begin
               state    <= RUN;
               pc_valid <= 1'b1;
            end
            RUN: begin
               if (trap_req || misaligned) begin
                  pc_current <= TRAP_VECTOR;
                  epc        <= pc_current;
                  trap_cause <= trap_req ? 2'b01 : 2'b10;
               end else if (!stall) begin
                  pc_current <= target;
                  instret    <= instret + CNT_W'(1);
                  if (halt_req) begin
                     state    <= HALT;
                     pc_valid <= 1'b0;
                  end
               end
            end
            HALT: begin
               if (trap_req) begin
                  pc_current <= TRAP_VECTOR;
                  epc        <= pc_current;
                  trap_cause <= 2'b01;
                  state      <= RUN;
                  pc_valid   <= 1'b1;
               end else if (resume) begin
                  state    <= RUN;
                  pc_valid <= 1'b1;
               end
            end
            default: begin
               state    <= BOOT;
               pc_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
